// File: rtl/sobel_pkg.sv
// Shared Sobel pipeline definitions: frame geometry and the write-side FSM state
// encoding, so the input and output stages agree on the same frame layout.
package sobel_pkg;

  localparam int IMG_WIDTH  = 128;
  localparam int IMG_HEIGHT = 96;
  localparam int PIX_W      = 8;

  typedef enum logic [1:0] {
    WAIT_SOF = 2'd0,
    WRITE    = 2'd1,
    DONE     = 2'd2
  } wr_state_e;

endpackage

// File: rtl/sobel_fb_ram.sv
// Simple dual-port frame-buffer RAM: one write port, one read port whose
// output is registered (read data appears one cycle after the address).
// Contents are never cleared; readers must mask data they do not trust.
module sobel_fb_ram #(
  parameter int DEPTH = 64,
  parameter int AW    = 6,
  parameter int DW    = 8
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  (* ram_style = "block" *) logic [DW-1:0] mem_r [DEPTH];

  // write port
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  // registered read port
  always_ff @(posedge clk) begin
    rdata <= mem_r[raddr];
  end

endmodule

// File: rtl/sobel_img_out.sv
// Sobel output stage: captures the raster-ordered result stream into a
// ping-pong frame store and serves random-access reads to the display.
// Banks swap only on a display frame start after a frame has completed, so
// the display always shows a whole frame.
module sobel_img_out
  import sobel_pkg::*;
#(
  parameter int WIDTH       = IMG_WIDTH,
  parameter int HEIGHT      = IMG_HEIGHT,
  parameter int BORDER_ZERO = 1,
  parameter int THRESH      = 0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [PIX_W-1:0]          in_pix,
  input  logic                      in_valid,
  input  logic                      in_sof,
  output logic                      in_ready,
  input  logic                      rd_frame_start,
  input  logic                      rd_en,
  input  logic [$clog2(WIDTH)-1:0]  rd_x,
  input  logic [$clog2(HEIGHT)-1:0] rd_y,
  output logic [PIX_W-1:0]          rd_pix,
  output logic                      rd_valid,
  output logic                      frame_done,
  output logic                      sync_err
);

  localparam int XW    = $clog2(WIDTH);
  localparam int YW    = $clog2(HEIGHT);
  localparam int FRAME = WIDTH * HEIGHT;
  localparam int DEPTH = 2 * FRAME;
  localparam int AW    = $clog2(DEPTH);

  // Linear frame-store address of pixel (x,y) in the given bank.
  function automatic logic [AW-1:0] pix_addr(input logic bank,
                                              input logic [XW-1:0] x,
                                              input logic [YW-1:0] y);
    logic [AW-1:0] base;
    if (bank) begin
      base = AW'(FRAME);
    end else begin
      base = '0;
    end
    return base + AW'(y) * AW'(WIDTH) + AW'(x);
  endfunction

  // Value actually stored: border forced to zero, then optional binarisation.
  function automatic logic [PIX_W-1:0] xform(input logic [PIX_W-1:0] pix,
                                              input logic [XW-1:0] x,
                                              input logic [YW-1:0] y);
    logic border;
    border = (x == '0) || (x == XW'(WIDTH - 1)) ||
             (y == '0) || (y == YW'(HEIGHT - 1));
    if ((BORDER_ZERO != 0) && border) begin
      return '0;
    end else if (THRESH == 0) begin
      return pix;
    end else if (pix >= PIX_W'(THRESH)) begin
      return '1;
    end else begin
      return '0;
    end
  endfunction

  wr_state_e        state_r, state_nxt_s;
  logic [XW-1:0]    x_r, x_nxt_s, wr_x_s;
  logic [YW-1:0]    y_r, y_nxt_s, wr_y_s;
  logic             bank_wr_r, bank_rd_r, frame_avail_r;
  logic             in_ready_r, frame_done_r, sync_err_r;
  logic             xfer_s, last_s;
  logic             wr_en_s, sync_err_s, done_s, swap_s;

  logic             rd_in_range_s;
  logic [AW-1:0]    rd_addr_s, rd_addr_r;
  logic             rd_en_r, rd_ok_r, rd_valid_r, rd_ok_d_r;
  logic [PIX_W-1:0] ram_q_s;

  assign xfer_s = in_valid & in_ready_r;
  assign last_s = (x_r == XW'(WIDTH - 1)) && (y_r == YW'(HEIGHT - 1));

  // write FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= WAIT_SOF;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // write FSM next-state logic; a swap request only counts once in DONE
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      WAIT_SOF: begin
        if (xfer_s && in_sof) begin
          state_nxt_s = WRITE;
        end else begin
          state_nxt_s = WAIT_SOF;
        end
      end
      WRITE: begin
        if (xfer_s && !in_sof && last_s) begin
          state_nxt_s = DONE;
        end else begin
          state_nxt_s = WRITE;
        end
      end
      DONE: begin
        if (rd_frame_start) begin
          state_nxt_s = WAIT_SOF;
        end else begin
          state_nxt_s = DONE;
        end
      end
      default: begin
        state_nxt_s = WAIT_SOF;
      end
    endcase
  end

  // write FSM outputs: which pixel gets written and which events fire
  always_comb begin
    wr_en_s    = 1'b0;
    wr_x_s     = x_r;
    wr_y_s     = y_r;
    sync_err_s = 1'b0;
    done_s     = 1'b0;
    swap_s     = 1'b0;
    case (state_r)
      WAIT_SOF: begin
        if (xfer_s && in_sof) begin
          wr_en_s = 1'b1;
          wr_x_s  = '0;
          wr_y_s  = '0;
        end else if (xfer_s) begin
          sync_err_s = 1'b1;
        end else begin
          wr_en_s = 1'b0;
        end
      end
      WRITE: begin
        if (xfer_s && in_sof) begin
          wr_en_s    = 1'b1;
          wr_x_s     = '0;
          wr_y_s     = '0;
          sync_err_s = 1'b1;
        end else if (xfer_s) begin
          wr_en_s = 1'b1;
          done_s  = last_s;
        end else begin
          wr_en_s = 1'b0;
        end
      end
      DONE: begin
        swap_s = rd_frame_start;
      end
      default: begin
        wr_en_s = 1'b0;
      end
    endcase
  end

  // raster position following the pixel just written; wraps by compare
  always_comb begin
    x_nxt_s = x_r;
    y_nxt_s = y_r;
    if (wr_en_s) begin
      if (wr_x_s == XW'(WIDTH - 1)) begin
        x_nxt_s = '0;
        if (wr_y_s == YW'(HEIGHT - 1)) begin
          y_nxt_s = '0;
        end else begin
          y_nxt_s = wr_y_s + YW'(1);
        end
      end else begin
        x_nxt_s = wr_x_s + XW'(1);
        y_nxt_s = wr_y_s;
      end
    end else begin
      x_nxt_s = x_r;
      y_nxt_s = y_r;
    end
  end

  // counters, bank selection and registered status outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      x_r           <= '0;
      y_r           <= '0;
      bank_wr_r     <= 1'b0;
      bank_rd_r     <= 1'b1;
      frame_avail_r <= 1'b0;
      in_ready_r    <= 1'b1;
      frame_done_r  <= 1'b0;
      sync_err_r    <= 1'b0;
    end else begin
      x_r          <= x_nxt_s;
      y_r          <= y_nxt_s;
      in_ready_r   <= (state_nxt_s != DONE);
      frame_done_r <= done_s;
      sync_err_r   <= sync_err_s;
      if (swap_s) begin
        bank_rd_r     <= bank_wr_r;
        bank_wr_r     <= ~bank_wr_r;
        frame_avail_r <= 1'b1;
      end
    end
  end

  // read address; out-of-range requests are parked at 0 and masked later
  always_comb begin
    rd_in_range_s = (int'(rd_x) < WIDTH) && (int'(rd_y) < HEIGHT);
    if (rd_in_range_s) begin
      rd_addr_s = pix_addr(bank_rd_r, rd_x, rd_y);
    end else begin
      rd_addr_s = '0;
    end
  end

  // read pipeline: stage 1 latches address/bank/qualifiers, stage 2 aligns with RAM data
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_addr_r  <= '0;
      rd_en_r    <= 1'b0;
      rd_ok_r    <= 1'b0;
      rd_valid_r <= 1'b0;
      rd_ok_d_r  <= 1'b0;
    end else begin
      rd_addr_r  <= rd_addr_s;
      rd_en_r    <= rd_en;
      rd_ok_r    <= rd_in_range_s & frame_avail_r;
      rd_valid_r <= rd_en_r;
      rd_ok_d_r  <= rd_ok_r;
    end
  end

  sobel_fb_ram #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .DW    (PIX_W)
  ) u_ram (
    .clk   (clk),
    .we    (wr_en_s),
    .waddr (pix_addr(bank_wr_r, wr_x_s, wr_y_s)),
    .wdata (xform(in_pix, wr_x_s, wr_y_s)),
    .raddr (rd_addr_r),
    .rdata (ram_q_s)
  );

  assign in_ready   = in_ready_r;
  assign frame_done = frame_done_r;
  assign sync_err   = sync_err_r;
  assign rd_valid   = rd_valid_r;
  assign rd_pix     = rd_ok_d_r ? ram_q_s : '0;

endmodule

// File: tb/tb_sobel_img_out.sv
// Directed bench for sobel_img_out: a full-size instance (border zeroing,
// no threshold) and a small 6x5 instance with THRESH=64.
module tb_sobel_img_out;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] in_pix;
  logic       in_valid, in_sof, in_ready, rd_frame_start, rd_en;
  logic [6:0] rd_x, rd_y;
  logic [7:0] rd_pix;
  logic       rd_valid, frame_done, sync_err;

  logic [7:0] t_in_pix;
  logic       t_in_valid, t_in_sof, t_in_ready, t_rd_frame_start, t_rd_en;
  logic [2:0] t_rd_x, t_rd_y;
  logic [7:0] t_rd_pix;
  logic       t_rd_valid, t_frame_done, t_sync_err;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int done_pulses = 0, err_pulses = 0, done_cyc = -1, err_cyc = -1;
  int last_cyc, sof_cyc, d0, e0;

  always #5 clk = ~clk;

  sobel_img_out #(.WIDTH(128), .HEIGHT(96), .BORDER_ZERO(1), .THRESH(0)) dut (
    .clk(clk), .rst(rst), .in_pix(in_pix), .in_valid(in_valid), .in_sof(in_sof),
    .in_ready(in_ready), .rd_frame_start(rd_frame_start), .rd_en(rd_en),
    .rd_x(rd_x), .rd_y(rd_y), .rd_pix(rd_pix), .rd_valid(rd_valid),
    .frame_done(frame_done), .sync_err(sync_err));

  sobel_img_out #(.WIDTH(6), .HEIGHT(5), .BORDER_ZERO(1), .THRESH(64)) dut_thr (
    .clk(clk), .rst(rst), .in_pix(t_in_pix), .in_valid(t_in_valid), .in_sof(t_in_sof),
    .in_ready(t_in_ready), .rd_frame_start(t_rd_frame_start), .rd_en(t_rd_en),
    .rd_x(t_rd_x), .rd_y(t_rd_y), .rd_pix(t_rd_pix), .rd_valid(t_rd_valid),
    .frame_done(t_frame_done), .sync_err(t_sync_err));

  // cycle counter used to time event pulses
  always @(posedge clk) cyc <= cyc + 1;

  // record frame_done / sync_err pulses of the full-size instance
  always @(negedge clk) begin
    if (frame_done) begin
      done_pulses++;
      done_cyc = cyc;
    end
    if (sync_err) begin
      err_pulses++;
      err_cyc = cyc;
    end
  end

  task automatic check_eq(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int gen(int kind, int x, int y, int w, int h);
    case (kind)
      0: return (x + y) & 255;
      1: return (x ^ (3 * y)) & 255;
      2: return (2 * x + 5 * y + 17) & 255;
      default: begin
        if (x == 0 || y == 0 || x == w - 1 || y == h - 1) return 255;
        return ((x + y) & 1) ? 64 : 63;
      end
    endcase
  endfunction

  function automatic int exp_pix(int kind, int x, int y, int w, int h, int thr);
    int v;
    if (x == 0 || y == 0 || x == w - 1 || y == h - 1) return 0;
    v = gen(kind, x, y, w, h);
    if (thr > 0) return (v >= thr) ? 255 : 0;
    return v;
  endfunction

  function automatic int got_valid(input bit sm);
    return sm ? int'(t_rd_valid) : int'(rd_valid);
  endfunction

  function automatic int got_pix(input bit sm);
    return sm ? int'(t_rd_pix) : int'(rd_pix);
  endfunction

  task automatic set_rd(input bit sm, input logic en, input int x, input int y);
    if (sm) begin
      t_rd_en = en; t_rd_x = 3'(x); t_rd_y = 3'(y);
    end else begin
      rd_en = en; rd_x = 7'(x); rd_y = 7'(y);
    end
  endtask

  task automatic send_px(input bit sm, input int p, input logic sof);
    if (sm) begin
      t_in_pix = 8'(p); t_in_sof = sof; t_in_valid = 1'b1;
    end else begin
      in_pix = 8'(p); in_sof = sof; in_valid = 1'b1;
    end
    last_cyc = cyc;
    tick();
  endtask

  task automatic pulse_fs(input bit sm);
    if (sm) t_rd_frame_start = 1'b1; else rd_frame_start = 1'b1;
    tick();
    t_rd_frame_start = 1'b0;
    rd_frame_start = 1'b0;
  endtask

  // one full frame, SOF on the first pixel; optional frame start on the last
  task automatic send_frame(input bit sm, input int kind, input bit fs_on_last);
    int w, h;
    w = sm ? 6 : 128;
    h = sm ? 5 : 96;
    for (int i = 0; i < w * h; i++) begin
      if (i == 0) sof_cyc = cyc;
      rd_frame_start = fs_on_last && (i == w * h - 1) && !sm;
      send_px(sm, gen(kind, i % w, i / w, w, h), i == 0);
    end
    rd_frame_start = 1'b0;
    in_valid = 1'b0; in_sof = 1'b0;
    t_in_valid = 1'b0; t_in_sof = 1'b0;
  endtask

  // n back-to-back raster reads starting at (x0,y0)
  task automatic read_run(input bit sm, input int x0, input int y0, input int n,
                          input int kind);
    int w, h, thr, s, idx;
    w = sm ? 6 : 128;
    h = sm ? 5 : 96;
    thr = sm ? 64 : 0;
    s = y0 * w + x0;
    for (int i = 0; i < n + 2; i++) begin
      if (i >= 2) begin
        idx = s + i - 2;
        check_eq("rd_valid_run", got_valid(sm), 1);
        check_eq("rd_pix_run", got_pix(sm), exp_pix(kind, idx % w, idx / w, w, h, thr));
      end else begin
        check_eq("rd_latency", got_valid(sm), 0);
      end
      if (i < n) set_rd(sm, 1'b1, (s + i) % w, (s + i) / w);
      else set_rd(sm, 1'b0, 0, 0);
      tick();
    end
  endtask

  task automatic read_one(input bit sm, input int x, input int y, input int expv);
    set_rd(sm, 1'b1, x, y);
    tick();
    set_rd(sm, 1'b0, 0, 0);
    check_eq("rd_lat1", got_valid(sm), 0);
    tick();
    check_eq("rd_valid", got_valid(sm), 1);
    check_eq("rd_pix", got_pix(sm), expv);
  endtask

  initial begin
    rst = 1'b1;
    in_pix = 8'd0; in_valid = 1'b0; in_sof = 1'b0; rd_frame_start = 1'b0;
    rd_en = 1'b0; rd_x = 7'd0; rd_y = 7'd0;
    t_in_pix = 8'd0; t_in_valid = 1'b0; t_in_sof = 1'b0; t_rd_frame_start = 1'b0;
    t_rd_en = 1'b0; t_rd_x = 3'd0; t_rd_y = 3'd0;
    tick();
    tick();
    rst = 1'b0;
    check_eq("rst_in_ready", in_ready, 1);
    check_eq("rst_rd_valid", rd_valid, 0);
    check_eq("rst_rd_pix", rd_pix, 0);
    check_eq("rst_frame_done", frame_done, 0);
    check_eq("rst_sync_err", sync_err, 0);
    check_eq("rst_t_in_ready", t_in_ready, 1);

    // threshold instance: 63 -> 0x00, 64 -> 0xFF, border forced to 0
    send_frame(1'b1, 3, 1'b0);
    check_eq("t_frame_done", t_frame_done, 1);
    check_eq("t_in_ready_done", t_in_ready, 0);
    pulse_fs(1'b1);
    check_eq("t_in_ready_swap", t_in_ready, 1);
    read_run(1'b1, 0, 0, 30, 3);
    read_one(1'b1, 2, 1, 255);
    read_one(1'b1, 2, 2, 0);
    read_one(1'b1, 7, 1, 0);

    // before any swap the display reads zero
    read_one(1'b0, 5, 5, 0);

    // ramp frame; frame start coincides with the last pixel and must not swap
    d0 = done_pulses; e0 = err_pulses;
    send_frame(1'b0, 0, 1'b1);
    check_eq("frame_done_hi", frame_done, 1);
    check_eq("in_ready_done", in_ready, 0);
    in_valid = 1'b1; in_pix = 8'hAA;
    for (int i = 0; i < 50; i++) begin
      check_eq("hold_in_ready", in_ready, 0);
      tick();
    end
    in_valid = 1'b0;
    check_eq("done_once", done_pulses - d0, 1);
    check_eq("done_timing", done_cyc, last_cyc + 1);
    check_eq("no_sync_err", err_pulses - e0, 0);
    read_one(1'b0, 5, 5, 0);
    pulse_fs(1'b0);
    check_eq("in_ready_swap", in_ready, 1);
    read_run(1'b0, 0, 0, 128 * 96, 0);
    read_one(1'b0, 100, 90, 190);
    read_one(1'b0, 1, 1, 2);

    // dropped pre-SOF pixels, then SOF again at pixel 700 restarts the frame
    d0 = done_pulses; e0 = err_pulses;
    for (int i = 0; i < 3; i++) send_px(1'b0, 8'h11, 1'b0);
    for (int i = 0; i < 700; i++) send_px(1'b0, 8'h5A, i == 0);
    send_frame(1'b0, 1, 1'b0);
    check_eq("restart_done_hi", frame_done, 1);
    tick();
    check_eq("restart_done_lo", frame_done, 0);
    check_eq("sync_err_count", err_pulses - e0, 4);
    check_eq("sync_err_timing", err_cyc, sof_cyc + 1);
    check_eq("restart_done_once", done_pulses - d0, 1);
    check_eq("restart_done_timing", done_cyc, last_cyc + 1);
    pulse_fs(1'b0);
    read_run(1'b0, 0, 0, 384, 1);
    read_run(1'b0, 0, 5, 128, 1);
    pulse_fs(1'b0);
    read_one(1'b0, 10, 10, 20);

    // reset in the middle of a frame
    for (int i = 0; i < 3000; i++) send_px(1'b0, gen(0, i % 128, i / 128, 128, 96), i == 0);
    in_valid = 1'b0; in_sof = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_eq("mid_rst_in_ready", in_ready, 1);
    check_eq("mid_rst_rd_valid", rd_valid, 0);
    check_eq("mid_rst_rd_pix", rd_pix, 0);
    read_one(1'b0, 10, 10, 0);
    send_frame(1'b0, 2, 1'b0);
    read_one(1'b0, 10, 10, 0);
    pulse_fs(1'b0);
    read_run(1'b0, 0, 50, 128, 2);
    read_one(1'b0, 10, 10, 87);
    read_one(1'b0, 5, 97, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
